// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator request arbiter: request-channel
// struct macro and the helper that sizes the requester-index id prefix.
`ifndef ACC_PKG_SV
`define ACC_PKG_SV

// Request channel payload, parameterised on address/data/id widths.
`define ACC_ARB_REQ_CHAN_T(name, AW, DW, IW) \
  typedef struct packed { \
    logic [(AW)-1:0]                 addr; \
    logic [acc_pkg::AccOpWidth-1:0]  data_op; \
    logic [(DW)-1:0]                 data_arga; \
    logic [(DW)-1:0]                 data_argb; \
    logic [(DW)-1:0]                 data_argc; \
    logic [(IW)-1:0]                 id; \
  } name;

package acc_pkg;

  localparam int unsigned AccOpWidth = 32;

  // Width of the requester index prepended to the downstream id.
  function automatic int unsigned idx_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

`endif

// File: rtl/acc_outstanding_ctr.sv
// Saturating up/down counter of unanswered requests for one requester.
module acc_outstanding_ctr #(
  parameter int unsigned MaxCount = 4,
  localparam int unsigned CntWidth = $clog2(MaxCount + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == CntWidth'(MaxCount));
  assign empty_o = (cnt_q == '0);

  // Simultaneous inc and dec cancel; never step past either end.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Arbiter must never accept a request for a full requester.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(inc_i && !dec_i && full_o))
        else $error("outstanding counter overflow");
    end
  end
`endif

endmodule

// File: rtl/acc_req_arbiter.sv
// Shares one accelerator request/response channel between NumReq requesters:
// round-robin request arbitration with grant lock and per-requester
// outstanding cap; responses are routed back by the id index prefix.
module acc_req_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 4,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxWidth      = idx_width(NumReq)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    slv_q_valid_i,
  output logic [NumReq-1:0]                    slv_q_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]     slv_q_addr_i,
  input  logic [NumReq-1:0][AccOpWidth-1:0]    slv_q_data_op_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     slv_q_data_arga_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     slv_q_data_argb_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     slv_q_data_argc_i,
  input  logic [NumReq-1:0][IdWidth-1:0]       slv_q_id_i,
  output logic                                 mst_q_valid_o,
  input  logic                                 mst_q_ready_i,
  output logic [AddrWidth-1:0]                 mst_q_addr_o,
  output logic [AccOpWidth-1:0]                mst_q_data_op_o,
  output logic [DataWidth-1:0]                 mst_q_data_arga_o,
  output logic [DataWidth-1:0]                 mst_q_data_argb_o,
  output logic [DataWidth-1:0]                 mst_q_data_argc_o,
  output logic [IdxWidth+IdWidth-1:0]          mst_q_id_o,
  input  logic                                 mst_p_valid_i,
  output logic                                 mst_p_ready_o,
  input  logic [DataWidth-1:0]                 mst_p_data_i,
  input  logic [IdxWidth+IdWidth-1:0]          mst_p_id_i,
  output logic [NumReq-1:0]                    slv_p_valid_o,
  input  logic [NumReq-1:0]                    slv_p_ready_i,
  output logic [DataWidth-1:0]                 slv_p_data_o,
  output logic [IdWidth-1:0]                   slv_p_id_o
);

  `ACC_ARB_REQ_CHAN_T(req_chan_t, AddrWidth, DataWidth, IdWidth)

  req_chan_t [NumReq-1:0] req_chan;
  req_chan_t              gnt_chan;
  logic [NumReq-1:0]      full, empty, eligible, p_hs_vec;
  logic [IdxWidth-1:0]    ptr_q, ptr_d, lock_idx_q, lock_idx_d, rr_idx, gnt_idx, rsp_idx;
  logic                   lock_q, lock_d, rr_found, q_valid, q_hs;
  logic                   rsp_legal, rsp_ready_sel;

  // Gather the per-requester request fields into structs for muxing.
  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_chan[i].addr      = slv_q_addr_i[i];
      req_chan[i].data_op   = slv_q_data_op_i[i];
      req_chan[i].data_arga = slv_q_data_arga_i[i];
      req_chan[i].data_argb = slv_q_data_argb_i[i];
      req_chan[i].data_argc = slv_q_data_argc_i[i];
      req_chan[i].id        = slv_q_id_i[i];
    end
  end

  assign eligible = slv_q_valid_i & ~full;

  // Two-pass round-robin: first from the pointer upward, then wrap from 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!rr_found && eligible[i] && (i >= 32'(ptr_q))) begin
        rr_found = 1'b1;
        rr_idx   = IdxWidth'(i);
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!rr_found && eligible[i]) begin
        rr_found = 1'b1;
        rr_idx   = IdxWidth'(i);
      end
    end
  end

  // A stalled grant is held so a newly eligible requester cannot preempt it.
  assign gnt_idx  = lock_q ? lock_idx_q : rr_idx;
  assign gnt_chan = req_chan[gnt_idx];
  assign q_valid  = !rst_i && (lock_q || rr_found);
  assign q_hs     = q_valid && mst_q_ready_i;

  assign mst_q_valid_o     = q_valid;
  assign mst_q_addr_o      = gnt_chan.addr;
  assign mst_q_data_op_o   = gnt_chan.data_op;
  assign mst_q_data_arga_o = gnt_chan.data_arga;
  assign mst_q_data_argb_o = gnt_chan.data_argb;
  assign mst_q_data_argc_o = gnt_chan.data_argc;
  assign mst_q_id_o        = {gnt_idx, gnt_chan.id};
  assign slv_q_ready_o     = q_valid ? (NumReq'(mst_q_ready_i) << gnt_idx) : '0;

  // Pointer advance (explicit modulo for non-power-of-2 NumReq) and lock.
  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (q_hs) begin
      ptr_d  = IdxWidth'((32'(gnt_idx) + 32'd1) % NumReq);
      lock_d = 1'b0;
    end else if (q_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
  end

  // Arbitration state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign rsp_idx = mst_p_id_i[IdxWidth+IdWidth-1 -: IdxWidth];

  // Decode the response index; out-of-range or idle requesters are illegal.
  always_comb begin
    rsp_legal     = 1'b0;
    rsp_ready_sel = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (32'(rsp_idx) == i) begin
        rsp_legal     = !empty[i];
        rsp_ready_sel = slv_p_ready_i[i];
      end
    end
  end

  // Illegal responses are swallowed so the downstream channel cannot stall.
  assign slv_p_valid_o = (!rst_i && rsp_legal && mst_p_valid_i) ? (NumReq'(1) << rsp_idx) : '0;
  assign mst_p_ready_o = !rst_i && (rsp_legal ? rsp_ready_sel : 1'b1);
  assign slv_p_data_o  = mst_p_data_i;
  assign slv_p_id_o    = mst_p_id_i[IdWidth-1:0];
  assign p_hs_vec      = slv_p_valid_o & slv_p_ready_i;

  for (genvar g = 0; g < NumReq; g++) begin : gen_ctr
    acc_outstanding_ctr #(
      .MaxCount (MaxOutstanding)
    ) u_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (slv_q_ready_o[g]),
      .dec_i   (p_hs_vec[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

`ifndef SYNTHESIS
  req_chan_t held_chan_q;

  // Remember the presented payload so a locked grant can be checked for stability.
  always_ff @(posedge clk_i) begin
    held_chan_q <= gnt_chan;
  end

  // Protocol checks on grant, lock and response routing.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(slv_q_ready_o)) else $error("multiple request grants");
      if (lock_q) begin
        assert (gnt_idx == lock_idx_q && gnt_chan == held_chan_q)
          else $error("locked grant changed");
      end
      if (mst_p_valid_i) begin
        assert (rsp_legal) else $warning("response to idle requester discarded");
      end
    end
  end
`endif

endmodule

// File: doc/acc_req_arbiter.md
Name: acc_req_arbiter

Overview:
- Shares one accelerator request/response channel between NumReq offloading adapters, e.g. several cores feeding one accelerator interconnect port.
- Request channel: round-robin arbitration with grant lock, and an outstanding-transaction cap per requester.
- The requester index is prepended to the downstream id; responses are routed back by that index.

Parameters:
- NumReq, 4, number of upstream requesters (>=2)
- DataWidth, 32, operand/result width
- AddrWidth, 4, accelerator address width
- IdWidth, 5, upstream transaction id width
- MaxOutstanding, 4, max unanswered requests per requester (>=1)
- IdxWidth, $clog2(NumReq), derived, do not override

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- slv_q_valid_i  in  NumReq  per-requester request valid
- slv_q_ready_o  out  NumReq  per-requester request ready
- slv_q_addr_i  in  NumReq x AddrWidth  target accelerator address
- slv_q_data_op_i  in  NumReq x 32  instruction word
- slv_q_data_arga_i / argb_i / argc_i  in  NumReq x DataWidth  operands
- slv_q_id_i  in  NumReq x IdWidth  transaction id
- mst_q_valid_o  out  1  downstream request valid
- mst_q_ready_i  in  1  downstream request ready
- mst_q_addr_o, mst_q_data_op_o, mst_q_data_arga/b/c_o  out  as above  muxed request fields
- mst_q_id_o  out  IdxWidth+IdWidth  {grant index, upstream id}
- mst_p_valid_i  in  1  response valid
- mst_p_ready_o  out  1  response ready
- mst_p_data_i  in  DataWidth  result
- mst_p_id_i  in  IdxWidth+IdWidth  response id
- slv_p_valid_o  out  NumReq  routed response valid
- slv_p_ready_i  in  NumReq  per-requester response ready
- slv_p_data_o  out  DataWidth  result, broadcast to all requesters
- slv_p_id_o  out  IdWidth  lower IdWidth bits of mst_p_id_i

Behaviour:
- Reset (rst_i high at a clock edge):
  - priority pointer := 0, lock := 0, all counters := 0
  - while rst_i is high, all valid/ready outputs are forced to 0
- Eligibility: eligible[i] = slv_q_valid_i[i] && cnt[i] != MaxOutstanding.
- Arbitration:
  - Combinational round-robin over eligible, starting at the pointer.
  - mst_q_valid_o = |eligible (or lock held); mux fields from the granted index.
  - Zero-cycle request latency.
- Lock:
  - If mst_q_valid_o && !mst_q_ready_i, the grant index is registered and held (lock=1) until the handshake.
  - Fields and valid must stay stable.
  - A higher-priority requester arriving meanwhile does not preempt.
- Handshake: slv_q_ready_o[g] = mst_q_ready_i for the granted g only; the others are 0. On the handshake, pointer := (g+1) mod NumReq and lock := 0.
- Counters:
  - cnt[g]++ on a q handshake; cnt[r]-- on a p handshake routed to r.
  - Both events in one cycle on the same r leave cnt unchanged.
  - cnt is IdxWidth-independent, width $clog2(MaxOutstanding+1); it never wraps.
- Response routing:
  - r = mst_p_id_i[IdxWidth+IdWidth-1:IdWidth]
  - slv_p_valid_o[r] = mst_p_valid_i; mst_p_ready_o = slv_p_ready_i[r]
  - Combinational, zero latency.
- Illegal response:
  - Condition: r >= NumReq, or cnt[r] == 0.
  - The response is dropped: mst_p_ready_o = 1, no slv_p_valid_o, counters unchanged.
  - A simulation assertion fires.
- Non-power-of-2 NumReq: pointer wrap uses explicit modulo, never bit truncation.
- Reset mid-transaction: all outstanding state is discarded, with no response replay. Upstream adapters are reset together.
- Assertions:
  - onehot0(slv_q_ready_o)
  - grant stable while locked
  - no counter overflow

Decomposition:
- Shared package acc_pkg gets:
  - arbiter id-layout helper function: idx_width(NumReq)
  - acc_arb_req_chan_t typedef macro, parameterised on addr/data/id
- Sub-module acc_outstanding_ctr: one saturating up/down counter with a full flag, instantiated NumReq times.
- Round-robin select: inline, priority-pointer plus two-pass scan.

Test Plan:
- NumReq=4, all valid continuously, mst_q_ready_i=1 -> grants cycle 0,1,2,3,0; mst_q_id_o[6:5] follows the same order.
- Req0 valid, mst_q_ready_i=0 for 3 cycles, req2 raises valid at cycle 1 -> grant stays 0 with stable fields; req0 handshakes at cycle 3, then req2 is granted.
- Req1 issues 4 requests with no responses (MaxOutstanding=4) -> 5th blocked, slv_q_ready_o[1]=0, req3 still served; one response to id {1,x} -> req1 eligible the next cycle.
- Response id=7'b10_00011 with slv_p_ready_i[2]=0 for 2 cycles -> slv_p_valid_o=4'b0100, mst_p_ready_o=0; when ready rises, slv_p_id_o=3 and cnt[2] decrements.
- Same-cycle q handshake and p handshake on requester 0 with cnt[0]=2 -> cnt[0] stays 2.
- Response id index 3 with cnt[3]=0 -> dropped, mst_p_ready_o=1, assertion fires; rst_i pulsed with 2 outstanding -> all counters 0, pointer 0.
